itch_msg_assembler: RTL and testbench
=====================================

# itch_msg_assembler

Parametrised ITCH message assembler. It accepts a beat stream of `DATA_BYTES`-wide words in which a fixed-length message can start at any byte lane. It realigns the message bytes into one flat register of `MSG_BYTES` bytes and presents the completed message on a valid/ready output. It sits behind the message-type dispatcher and replaces the per-message, bit-tracker parsers with one generic engine per message length. It also reports where the next message begins inside the final beat.

## Interface
- `DATA_BYTES`, 8: input beat width in bytes (power of two, ≥4).
- `MSG_BYTES`, 28: message length in bytes (Order Book State: ts 4 + id 4 + name 20).
- `OFF_W`, $clog2(DATA_BYTES): width of the byte-offset fields.
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: beat valid.
- `in_ready`  out  1: beat accepted when `in_valid && in_ready`.
- `in_data`  in  8*DATA_BYTES: beat; lane k = `in_data[8k+7:8k]`.
- `in_start`  in  1: beat holds message byte 0.
- `in_offset`  in  OFF_W: lane of message byte 0; meaningful only with `in_start`.
- `last_beat`  out  1: combinational; the beat being accepted completes the message.
- `next_offset`  out  OFF_W: combinational; lane after the message's last byte in that beat (0 = beat fully consumed).
- `msg_valid`  out  1: assembled message available.
- `msg_ready`  in  1: consumer accepts the message.
- `msg_data`  out  8*MSG_BYTES: message byte j = `msg_data[8j+7:8j]`.
- `err`  out  1: one-cycle protocol error pulse.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - COLLECT: `in_ready`=1.
  - HOLD: `msg_valid`=1, `in_ready`=`msg_ready`.
- Byte counter `bcnt`, width $clog2(MSG_BYTES+1), counts message bytes captured so far.
- Start beat (IDLE, or HOLD with `msg_ready`):
  - lane k writes message byte j = k − `in_offset` for 0 ≤ j < MSG_BYTES;
  - `bcnt` ← min(DATA_BYTES − `in_offset`, MSG_BYTES).
- Continuation beat (COLLECT):
  - lane k writes byte j = `bcnt` + k for j < MSG_BYTES;
  - `bcnt` += DATA_BYTES, saturating at MSG_BYTES.
- `last_beat` = accepted beat with `bcnt` + captured ≥ MSG_BYTES. `next_offset` = (`in_offset` + MSG_BYTES) mod DATA_BYTES, latched at start.
- Transitions:
  - IDLE → COLLECT on a start beat.
  - IDLE → HOLD when the start beat is also the last beat (`in_offset` + MSG_BYTES ≤ DATA_BYTES).
  - COLLECT → HOLD on the last beat.
  - HOLD → IDLE on `msg_ready` with no start beat.
  - HOLD → COLLECT or HOLD on `msg_ready` with an accepted start beat, which is processed exactly as from IDLE.
- Error cases:
  - `in_start` in COLLECT: pulse `err`, discard the partial message, restart with this beat as a start beat.
  - Beat without `in_start` in IDLE: accepted, dropped, pulse `err`.
- `in_valid` low: all state holds; gaps are allowed anywhere.
- Bytes of `msg_data` not yet written in the current message are not cleared. Only the final message content is defined.

## Timing
- Reset values:
  - `msg_valid`=0, `msg_data`=0, `err`=0;
  - state IDLE, `bcnt`=0, latched `next_offset`=0;
  - `in_ready`=1 in the cycle after reset.
- `rst` has priority over every event. Reset mid-message discards the partial message with no `err`.
- Latency: `msg_valid` rises on the clock edge that accepts the last beat, so it is visible the next cycle.
- `msg_data` is stable while `msg_valid`=1 and `msg_ready`=0.
- Throughput: back-to-back messages with no bubble when `msg_ready`=1 in HOLD.
- `last_beat` and `next_offset` are valid in the same cycle as the accepting handshake. The upstream dispatcher uses them to re-present the final beat as the next start beat with `in_offset`=`next_offset`.
- `err` is registered: it pulses the cycle after the offending beat.

## Structure
- Package `itch_pkg` holds:
  - message length constants (`ORDER_BOOK_STATE_BYTES`=28, etc.);
  - field byte positions for slicing `msg_data`: ts [3:0], id [7:4], name [27:8];
  - the FSM state enum.
- Sub-module `itch_lane_shifter`: combinational byte realign of a beat by a signed lane shift, with a per-byte write-enable mask. Instantiated once.

## Test plan
All scenarios use `DATA_BYTES`=8 and `MSG_BYTES`=28. Each stream byte value equals its stream index.

1. Offset 0: start at lane 0, 4 beats (bytes 0x00–0x1F) → `msg_data` bytes = 0x00..0x1B; `last_beat` on beat 4 with `next_offset`=4; `msg_valid` the next cycle.
2. Offset 4: 4 beats → bytes 0x04..0x1F captured; `next_offset`=0; ts = 0x07060504.
3. Offset 5 with an `in_valid` gap after beat 2: 5 beats → message bytes 0x05..0x20; `next_offset`=1; the gap does not change the result.
4. Backpressure:
   - hold `msg_ready`=0 for 3 cycles → `msg_data` stable, `in_ready`=0;
   - then raise `msg_ready` with a new start beat (offset 4) → accepted in the same cycle, second message correct.
5. `in_start` on beat 3 of a message → `err` pulses one cycle; the first message is never presented; the new message assembles correctly.
6. `rst` asserted during beat 2 → all outputs at reset values; `err`=0; a following offset-0 message assembles correctly.

Source files
------------

// File: rtl/itch_pkg.sv
// ITCH message lengths, Order Book State field byte positions and assembler FSM states.
// Pure definitions: no latency, no flow control.
package itch_pkg;

  localparam int SYSTEM_EVENT_BYTES     = 12;
  localparam int ORDER_BOOK_STATE_BYTES = 28;
  localparam int ADD_ORDER_BYTES        = 36;

  // Byte positions inside msg_data for an Order Book State message
  localparam int TS_LO   = 0;
  localparam int TS_HI   = 3;
  localparam int ID_LO   = 4;
  localparam int ID_HI   = 7;
  localparam int NAME_LO = 8;
  localparam int NAME_HI = 27;

  typedef struct packed {
    logic [8*20-1:0] name;
    logic [31:0]     id;
    logic [31:0]     ts;
  } orderBookState_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } asmState_t;

endpackage

// File: rtl/itch_lane_shifter.sv
// Moves beat lane k to message byte k+shift and flags which message bytes were written.
// Combinational, zero latency; no flow control.
module itch_lane_shifter #(
  parameter int DATA_BYTES = 8,
  parameter int MSG_BYTES  = 28,
  parameter int SHIFT_W    = 6
) (
  input  logic [8*DATA_BYTES-1:0]   beat,
  input  logic signed [SHIFT_W-1:0] shift,
  output logic [8*MSG_BYTES-1:0]    shifted,
  output logic [MSG_BYTES-1:0]      byteEn
);

  always_comb begin
    shifted = '0;
    byteEn  = '0;
    for (int j = 0; j < MSG_BYTES; j++) begin
      for (int k = 0; k < DATA_BYTES; k++) begin
        if (k + int'(shift) == j) begin
          shifted[8*j +: 8] = beat[8*k +: 8];
          byteEn[j]         = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/itch_msg_assembler.sv
// Realigns a fixed-length ITCH message starting at any lane into one flat register.
// msg_valid rises the cycle after the last beat; in HOLD in_ready follows msg_ready.
module itch_msg_assembler
  import itch_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int MSG_BYTES  = ORDER_BOOK_STATE_BYTES,
  parameter int OFF_W      = $clog2(DATA_BYTES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic                    in_start,
  input  logic [OFF_W-1:0]        in_offset,
  output logic                    last_beat,
  output logic [OFF_W-1:0]        next_offset,
  output logic                    msg_valid,
  input  logic                    msg_ready,
  output logic [8*MSG_BYTES-1:0]  msg_data,
  output logic                    err
);

  localparam int CNT_W = $clog2(MSG_BYTES + 1);
  localparam int SUM_W = $clog2(MSG_BYTES + DATA_BYTES + 1);
  localparam int SH_W  = ((CNT_W > OFF_W) ? CNT_W : OFF_W) + 1;
  localparam logic [OFF_W-1:0] MSG_MOD = OFF_W'(MSG_BYTES % DATA_BYTES);

  asmState_t              state, stateNext;
  logic [CNT_W-1:0]       bcnt;
  logic [OFF_W-1:0]       nextOffReg;
  logic [8*MSG_BYTES-1:0] msgData;
  logic                   errReg;

  logic                   accept, startBeat, contBeat, wrEn, protoErr;
  logic [SUM_W-1:0]       captured, bcntBase, bcntSum;
  logic [CNT_W-1:0]       bcntNext;
  logic signed [SH_W-1:0] shift;
  logic [8*MSG_BYTES-1:0] shifted;
  logic [MSG_BYTES-1:0]   byteEn;
  logic                   msgValid;

  assign in_ready  = (state != ST_HOLD) || msg_ready;
  assign accept    = in_valid && in_ready;
  // Any accepted in_start restarts, including mid-message in COLLECT
  assign startBeat = accept && in_start;
  assign contBeat  = accept && !in_start && (state == ST_COLLECT);
  assign wrEn      = startBeat || contBeat;
  assign protoErr  = accept && (in_start ? (state == ST_COLLECT) : (state != ST_COLLECT));

  assign captured  = startBeat ? SUM_W'(DATA_BYTES) - SUM_W'(in_offset) : SUM_W'(DATA_BYTES);
  assign bcntBase  = startBeat ? '0 : SUM_W'(bcnt);
  assign bcntSum   = bcntBase + captured;
  assign last_beat = wrEn && (bcntSum >= SUM_W'(MSG_BYTES));
  assign bcntNext  = last_beat ? CNT_W'(MSG_BYTES) : CNT_W'(bcntSum);

  assign next_offset = startBeat ? in_offset + MSG_MOD : nextOffReg;
  assign shift       = startBeat ? SH_W'(0) - SH_W'(in_offset) : SH_W'(bcnt);

  itch_lane_shifter #(
    .DATA_BYTES(DATA_BYTES),
    .MSG_BYTES (MSG_BYTES),
    .SHIFT_W   (SH_W)
  ) u_shifter (
    .beat   (in_data),
    .shift  (shift),
    .shifted(shifted),
    .byteEn (byteEn)
  );

  always_comb begin
    stateNext = state;
    msgValid  = (state == ST_HOLD);
    if (wrEn)
      stateNext = last_beat ? ST_HOLD : ST_COLLECT;
    else if (state == ST_HOLD && msg_ready)
      stateNext = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt       <= '0;
      nextOffReg <= '0;
      msgData    <= '0;
      errReg     <= 1'b0;
    end else begin
      errReg <= protoErr;
      if (wrEn) bcnt <= bcntNext;
      if (startBeat) nextOffReg <= in_offset + MSG_MOD;
      for (int j = 0; j < MSG_BYTES; j++) begin
        if (wrEn && byteEn[j]) msgData[8*j +: 8] <= shifted[8*j +: 8];
      end
    end
  end

  assign msg_valid = msgValid;
  assign msg_data  = msgData;
  assign err       = errReg;

endmodule

// File: tb/tb_itch_msg_assembler.sv
// Directed bench for itch_msg_assembler with DATA_BYTES=8, MSG_BYTES=28; stream byte value = stream index.
module tb_itch_msg_assembler;
  import itch_pkg::*;

  typedef logic [8*28-1:0] word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_start, last_beat, msg_valid, msg_ready, err;
  logic [63:0] in_data;
  logic [2:0]  in_offset, next_offset;
  logic [8*28-1:0] msg_data;

  int checks   = 0;
  int failures = 0;

  itch_msg_assembler #(.DATA_BYTES(8), .MSG_BYTES(28), .OFF_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_start   (in_start),
    .in_offset  (in_offset),
    .last_beat  (last_beat),
    .next_offset(next_offset),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .msg_data   (msg_data),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mkBeat(input int b);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = 8'(8*b + k);
    return v;
  endfunction

  function automatic word_t expMsg(input int off);
    word_t m;
    for (int j = 0; j < 28; j++) m[8*j +: 8] = 8'(off + j);
    return m;
  endfunction

  // Presents one beat for one clock; samples combinational outputs mid-cycle.
  task automatic sendBeat(input int b, input logic st, input int off, input logic mr, input logic rs,
                          output logic lb, output logic [2:0] no, output logic rdy, output logic errPrev);
    @(negedge clk);
    errPrev   = err;
    in_valid  = 1'b1;
    in_data   = mkBeat(b);
    in_start  = st;
    in_offset = 3'(off);
    msg_ready = mr;
    rst       = rs;
    #1;
    lb  = last_beat;
    no  = next_offset;
    rdy = in_ready;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_start  = 1'b0;
    msg_ready = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic runMsg(input string tag, input int off, input int gapAfter, input logic firstReady,
                        input logic expErr);
    int n;
    logic lb, rdy, e;
    logic [2:0] no;
    n = (off + 28 + 7) / 8;
    for (int b = 0; b < n; b++) begin
      sendBeat(b, b == 0, off, (b == 0) ? firstReady : 1'b0, 1'b0, lb, no, rdy, e);
      check({tag, "_rdy"}, word_t'(rdy), word_t'(1));
      check({tag, "_last"}, word_t'(lb), word_t'(b == n - 1));
      if (b == n - 1) check({tag, "_noff"}, word_t'(no), word_t'((off + 28) % 8));
      if (b == 1) check({tag, "_err1"}, word_t'(e), word_t'(expErr));
      if (b == 2) check({tag, "_err2"}, word_t'(e), word_t'(0));
      if (b == gapAfter) repeat (3) @(posedge clk);
    end
    @(negedge clk);
    check({tag, "_vld"}, word_t'(msg_valid), word_t'(1));
    check({tag, "_data"}, msg_data, expMsg(off));
  endtask

  task automatic releaseMsg(input string tag);
    @(negedge clk);
    msg_ready = 1'b1;
    @(posedge clk);
    #1 msg_ready = 1'b0;
    @(negedge clk);
    check({tag, "_drain"}, word_t'(msg_valid), word_t'(0));
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_vld"},  word_t'(msg_valid), word_t'(0));
    check({tag, "_data"}, msg_data, word_t'(0));
    check({tag, "_err"},  word_t'(err), word_t'(0));
    check({tag, "_rdy"},  word_t'(in_ready), word_t'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic lb, rdy, e;
    logic [2:0] no;
    orderBookState_t obs;

    rst = 1'b1; in_valid = 1'b0; in_start = 1'b0; in_offset = '0; in_data = '0; msg_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    checkReset("reset");

    // 1: offset 0
    runMsg("s1", 0, -1, 1'b0, 1'b0);
    releaseMsg("s1");

    // Non-start beat while idle is dropped with an error pulse
    sendBeat(2, 1'b0, 0, 1'b0, 1'b0, lb, no, rdy, e);
    check("idle_drop_rdy", word_t'(rdy), word_t'(1));
    @(negedge clk);
    check("idle_drop_err", word_t'(err), word_t'(1));
    check("idle_drop_vld", word_t'(msg_valid), word_t'(0));

    // 2: offset 4, check timestamp and id fields
    runMsg("s2", 4, -1, 1'b0, 1'b0);
    check("s2_ts", word_t'(msg_data[8*TS_HI+7 : 8*TS_LO]), word_t'(32'h07060504));
    obs = msg_data;
    check("s2_id", word_t'(obs.id), word_t'(32'h0B0A0908));
    check("s2_name0", word_t'(msg_data[8*NAME_LO +: 8]), word_t'(8'h0C));
    releaseMsg("s2");

    // 3: offset 5, valid gap after beat 2
    runMsg("s3", 5, 1, 1'b0, 1'b0);
    releaseMsg("s3");

    // 4: backpressure, then new start accepted as msg_ready rises
    runMsg("s4a", 0, -1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_start = 1'b1; in_offset = 3'd4; in_data = mkBeat(0); msg_ready = 1'b0;
      #1;
      check("s4_stall_rdy", word_t'(in_ready), word_t'(0));
      check("s4_stall_vld", word_t'(msg_valid), word_t'(1));
      check("s4_stall_data", msg_data, expMsg(0));
    end
    runMsg("s4b", 4, -1, 1'b1, 1'b0);
    releaseMsg("s4");

    // 5: in_start on beat 3 aborts the first message
    sendBeat(0, 1'b1, 0, 1'b0, 1'b0, lb, no, rdy, e);
    sendBeat(1, 1'b0, 0, 1'b0, 1'b0, lb, no, rdy, e);
    check("s5_abort_last", word_t'(lb), word_t'(0));
    runMsg("s5", 2, -1, 1'b0, 1'b1);
    releaseMsg("s5");

    // 6: reset during beat 2
    sendBeat(0, 1'b1, 0, 1'b0, 1'b0, lb, no, rdy, e);
    sendBeat(1, 1'b0, 0, 1'b0, 1'b1, lb, no, rdy, e);
    @(negedge clk);
    checkReset("s6_rst");
    runMsg("s6", 0, -1, 1'b0, 1'b0);
    releaseMsg("s6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
